// File: rtl/zx8x_sync_gen.sv
// rtl/zx8x_sync_gen.sv - ZX80/ZX81 CPU-side sync, NMI/WAIT and re-timed video raster
`timescale 1ns/1ps

module zx8x_sync_gen #(
  parameter int LINE_CYC   = 207,
  parameter int HS_START   = 16,
  parameter int HS_END     = 32,
  parameter int OUT_LINE   = 414,
  parameter int OUT_HS_END = 32,
  parameter int HB_START   = 408,
  parameter int HB_END     = 64,
  parameter int VS_HIST    = 5,
  parameter int VS_TAP     = 2,
  parameter int STD_SPLIT  = 288
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce_cpu_n,
  input  logic       ce_pix,
  input  logic       zx81,
  input  logic       nm1,
  input  logic       niorq,
  input  logic       nrd,
  input  logic       nwr,
  input  logic       nhalt,
  input  logic [1:0] addr_lo,
  output logic       hsync,
  output logic       nmi_n,
  output logic       wait_n,
  output logic       vs,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       hblank,
  output logic       vblank,
  output logic [9:0] lines_per_frame,
  output logic       std_50,
  output logic       locked
);

  localparam int CW = (LINE_CYC > 1) ? $clog2(LINE_CYC) : 1;
  localparam int OW = (OUT_LINE > 1) ? $clog2(OUT_LINE) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(LINE_CYC - 1);
  localparam logic [CW-1:0] HS_SET     = CW'(HS_START - 1);
  localparam logic [CW-1:0] HS_CLR     = CW'(HS_END - 1);
  localparam logic [OW-1:0] OUT_LAST   = OW'(OUT_LINE - 1);
  localparam logic [OW-1:0] OUT_HS_LIM = OW'(OUT_HS_END);
  localparam logic [OW-1:0] HB_SET     = OW'(HB_START);
  localparam logic [OW-1:0] HB_CLR     = OW'(HB_END);
  localparam logic [9:0]    LINE_MAX   = 10'd1023;
  localparam logic [9:0]    STD_LIM    = 10'(STD_SPLIT);

  // CPU-side state
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hsync_q, hsync_d;
  logic          latch_q, latch_d;
  logic          vs_q, vs_d;
  logic          vsync_q, vsync_d;

  // Pixel-side raster state
  logic [OW-1:0]      out_cnt_q, out_cnt_d;
  logic               hs_prev_q, hs_prev_d;
  logic [VS_HIST-1:0] hist_q, hist_d;
  logic               hsync_out_q, hsync_out_d;
  logic               hblank_q, hblank_d;
  logic               vblank_q, vblank_d;
  logic               vsync_out_q, vsync_out_d;

  // Frame measurement state
  logic       vso_prev_q, vso_prev_d;
  logic [9:0] line_cnt_q, line_cnt_d;
  logic [9:0] lpf_q, lpf_d;
  logic       locked_q, locked_d;

  logic int_ack;
  logic io_wr;
  logic kbd_rd;
  logic hs_rise;
  logic realign;
  logic vso_rise;

  assign int_ack  = ~nm1 & ~niorq;
  assign io_wr    = ~niorq & ~nwr;
  assign kbd_rd   = ~niorq & ~nrd & ~addr_lo[0];
  assign hs_rise  = ce_pix & hsync_q & ~hs_prev_q;
  assign realign  = hs_rise & hist_q[VS_TAP+1] & hist_q[VS_TAP];
  assign vso_rise = vsync_out_q & ~vso_prev_q;

  // Line counter and raw hsync; interrupt acknowledge restarts the line
  always_comb begin
    cnt_d   = cnt_q;
    hsync_d = hsync_q;
    if (int_ack) begin
      cnt_d   = '0;
      hsync_d = 1'b0;
    end else if (ce_cpu_n) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      if (cnt_q == HS_SET) begin
        hsync_d = 1'b1;
      end else if (cnt_q == HS_CLR) begin
        hsync_d = 1'b0;
      end
    end
  end

  // NMI enable latch and vsync from IO side effects; vsync only moves outside hsync
  always_comb begin
    latch_d = latch_q;
    if (!zx81) begin
      latch_d = 1'b0;
    end else if (io_wr && (addr_lo[0] ^ addr_lo[1])) begin
      latch_d = addr_lo[1];
    end

    vs_d = vs_q;
    if (!latch_q) begin
      if (io_wr) begin
        vs_d = 1'b0;
      end else if (kbd_rd) begin
        vs_d = 1'b1;
      end
    end

    vsync_d = hsync_q ? vsync_q : vs_q;
  end

  // Fixed pixel raster, re-aligned to the CPU sync once vsync has been seen on two lines
  always_comb begin
    out_cnt_d   = out_cnt_q;
    hs_prev_d   = hs_prev_q;
    hist_d      = hist_q;
    hsync_out_d = hsync_out_q;
    hblank_d    = hblank_q;
    vblank_d    = vblank_q;
    vsync_out_d = vsync_out_q;

    if (ce_pix) begin
      hs_prev_d = hsync_q;
      if (realign) begin
        out_cnt_d = '0;
      end else if (out_cnt_q == OUT_LAST) begin
        out_cnt_d = '0;
      end else begin
        out_cnt_d = out_cnt_q + OW'(1);
      end
      hsync_out_d = (out_cnt_d < OUT_HS_LIM);
      if (out_cnt_d == HB_SET) begin
        hblank_d = 1'b1;
      end else if (out_cnt_d == HB_CLR) begin
        hblank_d = 1'b0;
      end
    end

    if (hs_rise) begin
      hist_d      = {hist_q[VS_HIST-2:0], vsync_q};
      vblank_d    = |hist_q;
      vsync_out_d = hist_q[VS_TAP];
    end
  end

  // Lines between vsync_out rises; a saturated count means sync is lost
  always_comb begin
    vso_prev_d = vsync_out_q;
    line_cnt_d = line_cnt_q;
    lpf_d      = lpf_q;
    locked_d   = locked_q;

    if (vso_rise) begin
      lpf_d      = line_cnt_q;
      locked_d   = (line_cnt_q == lpf_q);
      line_cnt_d = '0;
    end else if (hs_rise && (line_cnt_q != LINE_MAX)) begin
      line_cnt_d = line_cnt_q + 10'd1;
    end

    if (line_cnt_q == LINE_MAX) begin
      locked_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      hsync_q     <= 1'b0;
      latch_q     <= 1'b0;
      vs_q        <= 1'b0;
      vsync_q     <= 1'b0;
      out_cnt_q   <= '0;
      hs_prev_q   <= 1'b0;
      hist_q      <= '0;
      hsync_out_q <= 1'b0;
      hblank_q    <= 1'b0;
      vblank_q    <= 1'b0;
      vsync_out_q <= 1'b0;
      vso_prev_q  <= 1'b0;
      line_cnt_q  <= '0;
      lpf_q       <= '0;
      locked_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hsync_q     <= hsync_d;
      latch_q     <= latch_d;
      vs_q        <= vs_d;
      vsync_q     <= vsync_d;
      out_cnt_q   <= out_cnt_d;
      hs_prev_q   <= hs_prev_d;
      hist_q      <= hist_d;
      hsync_out_q <= hsync_out_d;
      hblank_q    <= hblank_d;
      vblank_q    <= vblank_d;
      vsync_out_q <= vsync_out_d;
      vso_prev_q  <= vso_prev_d;
      line_cnt_q  <= line_cnt_d;
      lpf_q       <= lpf_d;
      locked_q    <= locked_d;
    end
  end

  assign hsync           = hsync_q;
  assign nmi_n           = ~(latch_q & hsync_q);
  assign wait_n          = ~(nhalt & ~nmi_n);
  assign vs              = vs_q;
  assign hsync_out       = hsync_out_q;
  assign vsync_out       = vsync_out_q;
  assign hblank          = hblank_q;
  assign vblank          = vblank_q;
  assign lines_per_frame = lpf_q;
  assign std_50          = (lpf_q >= STD_LIM);
  assign locked          = locked_q;

endmodule

// File: tb/tb_zx8x_sync_gen.sv
// tb/tb_zx8x_sync_gen.sv - randomized and directed bench for zx8x_sync_gen against a line/frame model
`timescale 1ns/1ps

module tb_zx8x_sync_gen;

  localparam int LC  = 24;
  localparam int HSS = 4;
  localparam int HSE = 8;
  localparam int OL  = 40;
  localparam int OHE = 6;
  localparam int HBS = 36;
  localparam int HBE = 8;
  localparam int VH  = 5;
  localparam int VT  = 2;
  localparam int SS  = 288;

  logic       clk_sys  = 1'b0;
  logic       reset_n  = 1'b1;
  logic       ce_cpu_n = 1'b0;
  logic       ce_pix   = 1'b0;
  logic       zx81     = 1'b0;
  logic       nm1      = 1'b1;
  logic       niorq    = 1'b1;
  logic       nrd      = 1'b1;
  logic       nwr      = 1'b1;
  logic       nhalt    = 1'b1;
  logic [1:0] addr_lo  = 2'b00;
  logic       hsync, nmi_n, wait_n, vs, hsync_out, vsync_out, hblank, vblank, std_50, locked;
  logic [9:0] lines_per_frame;

  zx8x_sync_gen #(
    .LINE_CYC(LC), .HS_START(HSS), .HS_END(HSE), .OUT_LINE(OL), .OUT_HS_END(OHE),
    .HB_START(HBS), .HB_END(HBE), .VS_HIST(VH), .VS_TAP(VT), .STD_SPLIT(SS)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_cpu_n(ce_cpu_n), .ce_pix(ce_pix), .zx81(zx81),
    .nm1(nm1), .niorq(niorq), .nrd(nrd), .nwr(nwr), .nhalt(nhalt), .addr_lo(addr_lo),
    .hsync(hsync), .nmi_n(nmi_n), .wait_n(wait_n), .vs(vs), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .hblank(hblank), .vblank(vblank), .lines_per_frame(lines_per_frame),
    .std_50(std_50), .locked(locked)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      if (failures >= 40) begin
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  endtask

  // ---------------- reference model ----------------
  // CPU position within the line; hsync is high exactly for positions HSS..HSE-1.
  int m_pos;
  bit m_latch, m_vs, m_vsync;
  int m_opos;
  bit m_pix_seen, m_hblank, m_hs_prev;
  bit m_hist[$];
  bit m_vso, m_vblank, m_vso_prev;
  int m_lines, m_lpf;
  bit m_locked;

  function automatic bit m_hsync();
    return (m_pos >= HSS) && (m_pos < HSE);
  endfunction

  task automatic m_reset();
    m_pos = 0; m_latch = 0; m_vs = 0; m_vsync = 0;
    m_opos = 0; m_pix_seen = 0; m_hblank = 0; m_hs_prev = 0;
    m_hist.delete();
    for (int i = 0; i < VH; i++) m_hist.push_back(1'b0);
    m_vso = 0; m_vblank = 0; m_vso_prev = 0;
    m_lines = 0; m_lpf = 0; m_locked = 0;
  endtask

  task automatic m_step();
    bit ack, iowr, kbd, hs, edge_hs, rise, tap_lo, tap_hi, any_h;
    int old_lines;
    ack  = !nm1 && !niorq;
    iowr = !niorq && !nwr;
    kbd  = !niorq && !nrd && !addr_lo[0];
    hs   = m_hsync();
    edge_hs = ce_pix && hs && !m_hs_prev;
    rise = m_vso && !m_vso_prev;
    m_vso_prev = m_vso;

    old_lines = m_lines;
    if (rise) begin
      m_locked = (m_lines == m_lpf);
      m_lpf    = m_lines;
      m_lines  = 0;
    end else if (edge_hs && m_lines < 1023) begin
      m_lines++;
    end
    if (old_lines == 1023) m_locked = 0;

    tap_lo = 0; tap_hi = 0;
    if (edge_hs) begin
      tap_lo = m_hist[VT];
      tap_hi = m_hist[VT+1];
      any_h = 0;
      foreach (m_hist[i]) any_h |= m_hist[i];
      m_vblank = any_h;
      m_vso = tap_lo;
      m_hist.push_front(m_vsync);
      void'(m_hist.pop_back());
    end

    if (ce_pix) begin
      m_hs_prev = hs;
      m_pix_seen = 1;
      if (edge_hs && tap_lo && tap_hi) m_opos = 0;
      else m_opos = (m_opos + 1) % OL;
      if (m_opos == HBS) m_hblank = 1;
      else if (m_opos == HBE) m_hblank = 0;
    end

    if (!hs) m_vsync = m_vs;
    if (!m_latch) begin
      if (iowr) m_vs = 0;
      else if (kbd) m_vs = 1;
    end
    if (!zx81) m_latch = 0;
    else if (iowr && (addr_lo[0] ^ addr_lo[1])) m_latch = addr_lo[1];

    if (ack) m_pos = 0;
    else if (ce_cpu_n) m_pos = (m_pos + 1) % LC;
  endtask

  function automatic logic [19:0] exp_vec();
    bit hs, nmi, wt;
    hs  = m_hsync();
    nmi = !(m_latch && hs);
    wt  = !(nhalt && !nmi);
    return {hs, nmi, wt, m_vs, (m_pix_seen && m_opos < OHE), m_vso, m_hblank, m_vblank,
            (m_lpf >= SS), m_locked, 10'(m_lpf)};
  endfunction

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) m_reset();
    else m_step();
  end

  always @(negedge clk_sys) begin
    if (chk_en)
      check("cycle", {12'b0, hsync, nmi_n, wait_n, vs, hsync_out, vsync_out, hblank, vblank,
                      std_50, locked, lines_per_frame}, {12'b0, exp_vec()});
  end

  // ---------------- clock-enable generator ----------------
  int ce_mode = 0;
  int div = 0;
  always @(negedge clk_sys) begin
    #1;
    case (ce_mode)
      0: begin ce_cpu_n = 1'b1; ce_pix = 1'b1; end
      1: begin div = (div + 1) % 8; ce_cpu_n = (div == 0); ce_pix = 1'b1; end
      default: begin
        ce_cpu_n = ($urandom_range(0, 1) == 1);
        ce_pix   = ($urandom_range(0, 3) != 0);
      end
    endcase
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic bus_idle();
    nm1 = 1'b1; niorq = 1'b1; nrd = 1'b1; nwr = 1'b1;
  endtask

  task automatic io(input bit wr, input logic [1:0] a);
    tick();
    niorq = 1'b0; addr_lo = a;
    if (wr) nwr = 1'b0; else nrd = 1'b0;
    tick();
    bus_idle();
  endtask

  task automatic wait_hs(input logic v, input int budget, input string tag);
    int n = 0;
    while (hsync !== v && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'b0, hsync}, {31'b0, v});
  endtask

  task automatic run_frame(input int n);
    for (int k = 0; k < n * LC; k++) begin
      tick();
      bus_idle();
      addr_lo = 2'b00;
      if (k == 12) begin niorq = 1'b0; nrd = 1'b0; addr_lo = 2'b10; end
      else if (k == 4 * LC + 12) begin niorq = 1'b0; nwr = 1'b0; addr_lo = 2'b11; end
    end
  endtask

  initial begin
    int n_hi, n_lo, r;
    m_reset();
    #2 reset_n = 1'b0;
    #1;
    check("reset_vec", {12'b0, hsync, nmi_n, wait_n, vs, hsync_out, vsync_out, hblank, vblank,
                        std_50, locked, lines_per_frame}, {12'b0, 20'b0110_0000_0000_0000_0000});
    chk_en = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;

    // Free-run, CPU enable every 8 clocks: 4 CPU cycles of hsync in a 24-cycle line
    ce_mode = 1;
    wait_hs(1'b0, 400, "fr_lo0");
    wait_hs(1'b1, 400, "fr_hi0");
    n_hi = 0;
    while (hsync === 1'b1 && n_hi < 1000) begin tick(); n_hi++; end
    check("hs_width", n_hi, (HSE - HSS) * 8);
    n_lo = 0;
    while (hsync === 1'b0 && n_lo < 1000) begin tick(); n_lo++; end
    check("hs_period", n_hi + n_lo, LC * 8);

    // NMI enabled by OUT FE, active only inside hsync
    zx81 = 1'b1;
    io(1'b1, 2'b10);
    wait_hs(1'b0, 400, "nmi_lo");
    wait_hs(1'b1, 400, "nmi_hi");
    check("nmi_on", nmi_n, 1'b0);
    check("wait_on", wait_n, 1'b0);
    nhalt = 1'b0;
    tick();
    check("wait_halted", wait_n, 1'b1);
    nhalt = 1'b1;
    io(1'b1, 2'b01);
    wait_hs(1'b0, 400, "nmi_off_lo");
    wait_hs(1'b1, 400, "nmi_off_hi");
    check("nmi_off", nmi_n, 1'b1);

    // ZX80 mode: the same OUT has no effect
    zx81 = 1'b0;
    io(1'b1, 2'b10);
    wait_hs(1'b0, 400, "zx80_lo");
    wait_hs(1'b1, 400, "zx80_hi");
    check("zx80_nmi", nmi_n, 1'b1);
    check("zx80_wait", wait_n, 1'b1);

    // Random bus traffic with irregular enables
    ce_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      tick();
      bus_idle();
      addr_lo = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 99);
      if (r < 3) begin nm1 = 1'b0; niorq = 1'b0; end
      else if (r < 9) begin niorq = 1'b0; nwr = 1'b0; end
      else if (r < 15) begin niorq = 1'b0; nrd = 1'b0; end
      if ($urandom_range(0, 199) == 0) zx81 = ~zx81;
      if ($urandom_range(0, 49) == 0) nhalt = ~nhalt;
    end

    // Flush vsync history before regular frames
    ce_mode = 0;
    tick();
    bus_idle();
    zx81 = 1'b0;
    nhalt = 1'b1;
    tick();
    io(1'b1, 2'b11);
    repeat (12 * LC) tick();

    // 312-line frames, then 262-line frames
    for (int f = 0; f < 3; f++) run_frame(312);
    check("lpf_312", lines_per_frame, 10'd312);
    check("std50_312", std_50, 1'b1);
    check("lock_312", locked, 1'b1);
    run_frame(262);
    check("lpf_span", lines_per_frame, 10'd312);
    run_frame(262);
    check("lpf_262", lines_per_frame, 10'd262);
    check("std50_262", std_50, 1'b0);
    check("lock_drop", locked, 1'b0);
    run_frame(262);
    check("lock_262", locked, 1'b1);

    // No frames: line counter saturates, lock lost, last measurement held
    bus_idle();
    repeat (1030 * LC) tick();
    check("sat_lock", locked, 1'b0);
    check("sat_lpf", lines_per_frame, 10'd262);

    // Asynchronous reset with NMI active
    zx81 = 1'b1;
    io(1'b1, 2'b10);
    wait_hs(1'b0, 100, "rst_lo");
    wait_hs(1'b1, 100, "rst_hi");
    check("rst_nmi_pre", nmi_n, 1'b0);
    @(posedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    check("rst_nmi", nmi_n, 1'b1);
    check("rst_wait", wait_n, 1'b1);
    check("rst_lpf", lines_per_frame, 10'd0);
    @(negedge clk_sys);
    #1 reset_n = 1'b1;
    repeat (2 * LC) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
